// File: rtl/reduce_gate_pkg.sv
// rtl/reduce_gate_pkg.sv - op codes and op helper functions for the reduction gate pipeline
//
// Contents:
//   op_e         3-bit op code. NAND/NOR/XNOR are the inverted AND/OR/XOR. Codes 6 and 7 behave as AND.
//   op_base      maps an op to the AND/OR/XOR function that the tree evaluates.
//   op_identity  returns the pad bit for an odd leftover lane: 1 for the AND family, 0 for OR/XOR.
//   op_invert    is true when the final result must be complemented.
package reduce_gate_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_RSV6 = 3'd6,
    OP_RSV7 = 3'd7
  } op_e;

  function automatic op_e op_base(op_e op);
    case (op)
      OP_OR, OP_NOR:   return OP_OR;
      OP_XOR, OP_XNOR: return OP_XOR;
      default:         return OP_AND;
    endcase
  endfunction

  function automatic logic op_identity(op_e op);
    return op_base(op) == OP_AND;
  endfunction

  function automatic logic op_invert(op_e op);
    return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
  endfunction

endpackage

// File: rtl/reduce_gate_stage.sv
// rtl/reduce_gate_stage.sv - one registered level of the reduction tree
//
// Parameters:
//   N_SRC  number of lanes entering this level
//   W      bits per lane
//   LAST   set on the final level; the inversion for NAND/NOR/XNOR is applied here
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   en                  advance enable (low while the pipeline output is stalled)
//   src_valid/op/data   beat entering this level, N_SRC lanes packed at [k*W +: W]
//   dst_valid/op/data   registered beat, ceil(N_SRC/2) lanes
module reduce_gate_stage
  import reduce_gate_pkg::*;
#(
  parameter int N_SRC = 2,
  parameter int W     = 1,
  parameter bit LAST  = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           src_valid,
  input  logic [2:0]                     src_op,
  input  logic [N_SRC*W-1:0]             src_data,
  output logic                           dst_valid,
  output logic [2:0]                     dst_op,
  output logic [((N_SRC+1)/2)*W-1:0]     dst_data
);

  localparam int N_DST = (N_SRC + 1) / 2;

  op_e                op;
  op_e                base;
  logic               inv;
  logic [N_DST*W-1:0] next_data;

  assign op   = op_e'(src_op);
  assign base = op_base(op);
  assign inv  = LAST && op_invert(op);

  for (genvar k = 0; k < N_DST; k++) begin : g_pair
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;

    assign a = src_data[2*k*W +: W];

    // An odd lane count leaves the last lane unpaired; pad it with the
    // identity so it passes through the combine unchanged.
    if (2*k + 1 < N_SRC) begin : g_real
      assign b = src_data[(2*k+1)*W +: W];
    end else begin : g_pad
      assign b = {W{op_identity(op)}};
    end

    always_comb begin
      case (base)
        OP_OR:   r = a | b;
        OP_XOR:  r = a ^ b;
        default: r = a & b;
      endcase
    end

    assign next_data[k*W +: W] = inv ? ~r : r;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dst_valid <= 1'b0;
      dst_op    <= 3'd0;
      dst_data  <= '0;
    end else if (en) begin
      dst_valid <= src_valid;
      dst_op    <= src_op;
      dst_data  <= next_data;
    end
  end

endmodule

// File: rtl/reduce_gate_pipe.sv
// rtl/reduce_gate_pipe.sv - pipelined N-input bitwise reduction gate with valid/ready handshakes
//
// Parameters:
//   N_IN  number of input lanes (>= 2)
//   W     bits per lane (>= 1)
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    input handshake
//   in_op                0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6/7 AND
//   in_lanes             lane k at [k*W +: W]
//   out_valid/out_ready  output handshake
//   out_y                reduced result
//   out_op               op code that produced out_y
//   hit_cnt              only when REDUCE_GATE_PIPE_CNT_EN is defined: saturating count of
//                        output handshakes whose out_y is all ones
// Latency is $clog2(N_IN) cycles. A stalled output freezes every level; bubbles are kept.
module reduce_gate_pipe
  import reduce_gate_pkg::*;
#(
  parameter int N_IN = 8,
  parameter int W    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [N_IN*W-1:0] in_lanes,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_y,
`ifdef REDUCE_GATE_PIPE_CNT_EN
  output logic [2:0]        out_op,
  output logic [15:0]       hit_cnt
`else
  output logic [2:0]        out_op
`endif
);

  localparam int L = $clog2(N_IN);

  logic stall;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  for (genvar j = 0; j < L; j++) begin : g_lvl
    localparam int NS = (N_IN + (1 << j) - 1) >> j;
    localparam int ND = (NS + 1) / 2;

    logic          v;
    logic [2:0]    op;
    logic [ND*W-1:0] d;

    if (j == 0) begin : g_first
      reduce_gate_stage #(.N_SRC(NS), .W(W), .LAST(L == 1)) u_stage (
        .clk       (clk),
        .rst       (rst),
        .en        (!stall),
        .src_valid (in_valid),
        .src_op    (in_op),
        .src_data  (in_lanes),
        .dst_valid (v),
        .dst_op    (op),
        .dst_data  (d)
      );
    end else begin : g_next
      reduce_gate_stage #(.N_SRC(NS), .W(W), .LAST(j == L - 1)) u_stage (
        .clk       (clk),
        .rst       (rst),
        .en        (!stall),
        .src_valid (g_lvl[j-1].v),
        .src_op    (g_lvl[j-1].op),
        .src_data  (g_lvl[j-1].d),
        .dst_valid (v),
        .dst_op    (op),
        .dst_data  (d)
      );
    end
  end

  assign out_valid = g_lvl[L-1].v;
  assign out_op    = g_lvl[L-1].op;
  assign out_y     = g_lvl[L-1].d;

`ifdef REDUCE_GATE_PIPE_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt <= 16'd0;
    end else if (out_valid && out_ready && (&out_y) && (hit_cnt != 16'hFFFF)) begin
      hit_cnt <= hit_cnt + 16'd1;
    end
  end
`endif

endmodule
